// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and count-decoded full/empty flags.
// Writes are dropped when full and reads are dropped when empty, both judged on pre-edge state.
module fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BITS  = 2
) (
  output logic [WIDTH-1:0] out,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] in,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             clk,
  input  logic             rst
);

  localparam int unsigned CNT_W = BITS + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [BITS-1:0]  wr_ptr;
  logic [BITS-1:0]  rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == CNT_W'(0));

  // Acceptance uses the flags as they stand before the edge.
  assign wr_ok = (write_en == 1'b1) && !full;
  assign rd_ok = (read_en == 1'b1) && !empty;

  // Storage has no reset; only pointers, count and the output register are cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + BITS'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + BITS'(1);
        out    <= mem[rd_ptr];
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             full;
    logic             empty;
    string            tag;
  } exp_t;

  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] in;
  logic             write_en;
  logic             read_en;
  logic             clk;
  logic             rst;

  int errors = 0;
  int checks = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_out;

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BITS(2)) dut (
    .out(out), .full(full), .empty(empty), .in(in),
    .write_en(write_en), .read_en(read_en), .clk(clk), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs settle after the rising edge; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".out"}, out, e.out);
      check({e.tag, ".full"}, WIDTH'(full), WIDTH'(e.full));
      check({e.tag, ".empty"}, WIDTH'(empty), WIDTH'(e.empty));
    end
  end

  // One clock of stimulus; the reference model is an unbounded queue limited to DEPTH.
  task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] d, input string tag);
    bit rd_ok;
    bit wr_ok;
    exp_t e;
    write_en = we;
    read_en  = re;
    in       = d;
    rd_ok = re && (model_q.size() != 0);
    wr_ok = we && (model_q.size() != DEPTH);
    @(posedge clk);
    if (rd_ok) model_out = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    e.out   = model_out;
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.tag   = tag;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #2;
    check({tag, ".out"}, out, '0);
    check({tag, ".full"}, WIDTH'(full), '0);
    check({tag, ".empty"}, WIDTH'(empty), WIDTH'(1'b1));
    rst = 1'b1;
    model_q.delete();
    model_out = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    rst       = 1'b0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    in        = '0;
    model_out = '0;
    #3;
    check("reset.out", out, '0);
    check("reset.full", WIDTH'(full), '0);
    check("reset.empty", WIDTH'(empty), WIDTH'(1'b1));
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, WIDTH'($urandom), "fill");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, WIDTH'($urandom), "overflow");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "drain");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "underflow");
    end

    // Half occupancy with simultaneous traffic keeps count at 2.
    step(1'b1, 1'b0, 8'h11, "half_fill");
    step(1'b1, 1'b0, 8'h22, "half_fill");
    for (int i = 0; i < 6; i++) begin
      p = WIDTH'(8'h30 + i);
      step(1'b1, 1'b1, p, "rw_half");
    end

    // Full: read wins, write rejected.
    step(1'b1, 1'b0, 8'hA0, "refill");
    step(1'b1, 1'b0, 8'hA1, "refill");
    step(1'b1, 1'b1, 8'hEE, "rw_full");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "drain_after_rw_full");

    // Empty: write wins, read rejected.
    step(1'b1, 1'b1, 8'h5C, "rw_empty");
    step(1'b0, 1'b1, '0, "read_rw_empty");

    // Asynchronous reset in the middle of traffic, then resume.
    step(1'b1, 1'b0, 8'h77, "pre_reset");
    step(1'b1, 1'b0, 8'h88, "pre_reset");
    write_en = 1'b0;
    read_en  = 1'b0;
    async_reset_check("midop_reset");
    step(1'b1, 1'b0, 8'h99, "post_reset");
    step(1'b0, 1'b1, '0, "post_reset_read");
    step(1'b0, 1'b0, '0, "idle");

    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
